// File: rtl/half_subtractor_cell.sv
// One combinational half-subtractor lane: d = a - b (mod 2), borrow when a < b.
module half_subtractor_cell (
  input  logic a,
  input  logic b,
  output logic d,
  output logic borrow
);

  assign d      = a ^ b;
  assign borrow = ~a & b;

endmodule

// File: rtl/half_subtractor.sv
// Registered bank of WIDTH independent half subtractors with a valid qualifier.
module half_subtractor #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] borrow,
  output logic             out_valid
);

  logic [WIDTH-1:0] d_n;
  logic [WIDTH-1:0] borrow_n;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    half_subtractor_cell u_cell (
      .a      (a[i]),
      .b      (b[i]),
      .d      (d_n[i]),
      .borrow (borrow_n[i])
    );
  end

  // Results load only on valid, so junk on a/b while idle never reaches d/borrow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d         <= '0;
      borrow    <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        d      <= d_n;
        borrow <= borrow_n;
      end
    end
  end

endmodule

// File: tb/tb_half_subtractor.sv
// Self-checking bench: WIDTH=1, 4 and 8 instances share stimulus against a lane-arithmetic model.
module tb_half_subtractor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] a, b;

  logic [7:0] d8, borrow8;
  logic [3:0] d4, borrow4;
  logic [0:0] d1, borrow1;
  logic       v8, v4, v1;

  logic [7:0] exp_d, exp_b;
  logic       exp_v;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  half_subtractor #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b),
    .d(d8), .borrow(borrow8), .out_valid(v8)
  );
  half_subtractor #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a[3:0]), .b(b[3:0]),
    .d(d4), .borrow(borrow4), .out_valid(v4)
  );
  half_subtractor #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a[0:0]), .b(b[0:0]),
    .d(d1), .borrow(borrow1), .out_valid(v1)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s observed=%b expected=%b at %0t", tag, obs, expv, $time);
    end
  endtask

  // Each lane is an independent integer a - b on {0,1}: nonzero result is d, negative is borrow.
  function automatic logic [15:0] ref_sub(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] dd, bb;
    for (int i = 0; i < 8; i++) begin
      int diff;
      diff  = int'(x[i]) - int'(y[i]);
      dd[i] = (diff != 0);
      bb[i] = (diff < 0);
    end
    return {bb, dd};
  endfunction

  task automatic check_all(input string tag);
    check({tag, "_d8"}, d8, exp_d);
    check({tag, "_b8"}, borrow8, exp_b);
    check({tag, "_v8"}, {7'd0, v8}, {7'd0, exp_v});
    check({tag, "_d4"}, {4'd0, d4}, {4'd0, exp_d[3:0]});
    check({tag, "_b4"}, {4'd0, borrow4}, {4'd0, exp_b[3:0]});
    check({tag, "_v4"}, {7'd0, v4}, {7'd0, exp_v});
    check({tag, "_d1"}, {7'd0, d1}, {7'd0, exp_d[0]});
    check({tag, "_b1"}, {7'd0, borrow1}, {7'd0, exp_b[0]});
    check({tag, "_v1"}, {7'd0, v1}, {7'd0, exp_v});
  endtask

  task automatic drive(input string tag, input logic v, input logic [7:0] aa, input logic [7:0] bb);
    logic [15:0] r;
    in_valid = v;
    a        = aa;
    b        = bb;
    @(posedge clk);
    #1;
    exp_v = v;
    if (v) begin
      r     = ref_sub(aa, bb);
      exp_d = r[7:0];
      exp_b = r[15:8];
    end
    check_all(tag);
  endtask

  task automatic model_reset();
    exp_d = '0;
    exp_b = '0;
    exp_v = 1'b0;
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Single-lane truth table on consecutive cycles.
    drive("tt01", 1'b1, 8'h00, 8'h01);
    check("tt01_const", {6'd0, borrow1, d1}, 8'b11);
    drive("tt00", 1'b1, 8'h00, 8'h00);
    check("tt00_const", {6'd0, borrow1, d1}, 8'b00);
    drive("tt11", 1'b1, 8'h01, 8'h01);
    check("tt11_const", {6'd0, borrow1, d1}, 8'b00);
    drive("tt10", 1'b1, 8'h01, 8'h00);
    check("tt10_const", {6'd0, borrow1, d1}, 8'b01);

    // Hold on invalid, including X inputs.
    drive("hold", 1'b0, 8'h00, 8'h01);
    check("hold_const", {5'd0, v1, borrow1, d1}, 8'b001);
    drive("holdx", 1'b0, 8'bx, 8'bx);

    drive("w4", 1'b1, 8'h03, 8'h05);
    check("w4_d_const", {4'd0, d4}, 8'b0110);
    check("w4_b_const", {4'd0, borrow4}, 8'b0100);

    // Async reset mid-cycle with nonzero outputs held.
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("arst");
    @(negedge clk);
    rst_n = 1'b1;

    // Reset mid-stream discards the captured result.
    drive("ms_in", 1'b1, 8'h00, 8'h01);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("ms_rst");
    @(negedge clk);
    rst_n = 1'b1;
    drive("ms_after", 1'b1, 8'h01, 8'h00);
    check("ms_after_const", {5'd0, v1, borrow1, d1}, 8'b101);

    for (int n = 0; n < 1000; n++) begin
      logic       v;
      logic [7:0] ra, rb;
      v  = 1'($urandom_range(0, 1));
      ra = 8'($urandom);
      rb = 8'($urandom);
      if (!v && ($urandom_range(0, 7) == 0)) begin
        ra = 8'bx;
        rb = 8'bz;
      end
      drive("rnd", v, ra, rb);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/half_subtractor.md
Name: half_subtractor

Overview:
- Registered bank of WIDTH independent 1-bit half subtractors: per bit, difference d = a XOR b and borrow = (NOT a) AND b.
- No borrow propagates between bits; each lane is a standalone a − b.
- Used as a leaf arithmetic primitive. Registered outputs with a valid qualifier let it sit directly in a pipelined datapath.

Parameters:
- WIDTH, 1, number of independent half-subtractor lanes (≥1).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  qualifies a and b this cycle.
- a  input  WIDTH  minuend bits, one per lane.
- b  input  WIDTH  subtrahend bits, one per lane.
- d  output  WIDTH  registered difference per lane.
- borrow  output  WIDTH  registered borrow-out per lane.
- out_valid  output  1  d and borrow hold a fresh result.

Behaviour:
- One clock; reset is asynchronous and active-low. rst_n low immediately forces d=0, borrow=0, out_valid=0, regardless of clk. Release is sampled on the next rising clk edge.
- Per lane i, combinational: d_n[i] = a[i] ^ b[i]; borrow_n[i] = ~a[i] & b[i].
- Lane truth table, (a,b) -> (d,borrow): (0,0)->(0,0); (0,1)->(1,1); (1,0)->(1,0); (1,1)->(0,0).
- Latency is exactly 1 cycle. On a rising edge with in_valid=1: d<=d_n, borrow<=borrow_n, out_valid<=1.
- On a rising edge with in_valid=0: d and borrow hold their previous values; out_valid<=0.
- Back-to-back valid inputs are accepted every cycle, with no stall and no backpressure.
- X/Z on a or b while in_valid=0 must not corrupt the held outputs.
- Reset asserted mid-stream discards the in-flight result. The first valid input after release appears one cycle later.
- Lanes are fully independent. WIDTH=1 reduces to the classic single-bit half subtractor.
- No other state: no counters, no FSM.

Decomposition:
- Shared package: none required. WIDTH is the only configuration and lives as a module parameter.
- Sub-module half_subtractor_cell: purely combinational 1-bit lane with inputs a, b and outputs d, borrow.
  - Instantiated WIDTH times via generate.
- The top level holds only the output registers and the valid flop.

Test Plan:
- Reset: drive rst_n=0 asynchronously mid-cycle with prior outputs nonzero -> d=0, borrow=0, out_valid=0 immediately, before any clk edge.
- WIDTH=1 truth table, in_valid=1, sequence (a,b) = (0,1), (0,0), (1,1), (1,0) on consecutive cycles -> one cycle later each: (d,borrow) = (1,1), (0,0), (0,0), (1,0); out_valid=1 throughout.
- Hold: apply a=1,b=0 valid, then in_valid=0 with a=0,b=1 -> d=1, borrow=0 held; out_valid drops to 0.
- WIDTH=4: a=4'b0011, b=4'b0101 valid -> d=4'b0110, borrow=4'b0100 after 1 cycle.
- Reset mid-stream: valid a=0,b=1 sampled, rst_n pulsed low before the next edge -> outputs 0. After release, valid a=1,b=0 -> d=1, borrow=0, out_valid=1 one cycle later.
- Random: 1000 random valid/invalid cycles at WIDTH=8, checked against the reference model d=a^b, borrow=~a&b with 1-cycle latency and hold-on-invalid.
